// File: rtl/control_interface_output.sv
// Double-buffered serialiser: sta captures into the back bank, an exchange streams the front bank.
// Optional macro OUTPUT_CHECKSUM_EN appends an XOR checksum word to each stream.
module control_interface_output #(
   parameter int N_OUT  = 13,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sta,
   input  logic [N_OUT*DATA_W-1:0]   I_s,
   input  logic                      exchange_data_sig,
   output logic [DATA_W-1:0]         I_METER,
   output logic                      valid_out,
   output logic                      last_out,
   output logic                      stale_out,
   output logic                      busy,
   output logic                      overrun,
   output logic                      done_sig
);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_SEND} state_t;

`ifdef OUTPUT_CHECKSUM_EN
   localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N_OUT);
`else
   localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N_OUT - 1);
`endif

   state_t              r_state;
   state_t              w_state_next;
   logic [DATA_W-1:0]   r_bank [2][N_OUT];
   logic                r_sel;
   logic                r_fresh;
   logic                r_stale;
   logic [ADDR_W-1:0]   r_k;
   logic                w_swap;
   logic                w_sel_next;
   logic                w_send;
   logic                w_k_last;
   logic [DATA_W-1:0]   w_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (exchange_data_sig) w_state_next = S_ARM;
         S_ARM:   w_state_next = S_SEND;
         S_SEND:  if (w_k_last) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   assign w_send     = (r_state == S_SEND);
   assign w_k_last   = (r_k == K_LAST);
   assign w_swap     = (r_state == S_ARM) && r_fresh;
   assign w_sel_next = r_sel ^ w_swap;
   assign busy       = (r_state != S_IDLE);

`ifdef OUTPUT_CHECKSUM_EN
   logic [DATA_W-1:0] r_csum;
   logic              w_is_csum;
   logic [ADDR_W-1:0] w_kidx;

   assign w_is_csum = (r_k == ADDR_W'(N_OUT));
   assign w_kidx    = w_is_csum ? '0 : r_k;
   assign w_word    = w_is_csum ? r_csum : r_bank[r_sel][w_kidx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       r_csum <= '0;
      else if (r_state == S_ARM)     r_csum <= '0;
      else if (w_send && !w_is_csum) r_csum <= r_csum ^ w_word;
   end
`else
   assign w_word = r_bank[r_sel][r_k];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned b = 0; b < 2; b++)
            for (int unsigned i = 0; i < N_OUT; i++)
               r_bank[b][i] <= '0;
         r_sel     <= 1'b0;
         r_fresh   <= 1'b0;
         r_stale   <= 1'b0;
         r_k       <= '0;
         I_METER   <= '0;
         valid_out <= 1'b0;
         last_out  <= 1'b0;
         stale_out <= 1'b0;
         overrun   <= 1'b0;
         done_sig  <= 1'b0;
      end else begin
         r_sel <= w_sel_next;
         // Capture targets the bank that is back after this edge's swap, so the stream is untouched.
         if (sta)
            for (int unsigned i = 0; i < N_OUT; i++)
               r_bank[~w_sel_next][i] <= I_s[i*DATA_W +: DATA_W];
         if (sta)
            r_fresh <= 1'b1;
         else if (w_swap)
            r_fresh <= 1'b0;
         if (r_state == S_ARM)
            r_stale <= ~r_fresh;
         if (w_send && !w_k_last) r_k <= r_k + 1'b1;
         else                     r_k <= '0;
         valid_out <= w_send;
         I_METER   <= w_send ? w_word : '0;
         last_out  <= w_send && w_k_last;
         stale_out <= w_send && r_stale;
         done_sig  <= last_out;
         if (exchange_data_sig && busy)
            overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_control_interface_output.sv
// Directed bench for control_interface_output: capture, resend, same-cycle and mid-stream capture, overrun and reset abort.
module tb_control_interface_output;

   localparam int N = 13;
   localparam int W = 32;
`ifdef OUTPUT_CHECKSUM_EN
   localparam int NW = N + 1;
`else
   localparam int NW = N;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           sta = 1'b0;
   logic [N*W-1:0] I_s = '0;
   logic           exchange_data_sig = 1'b0;
   logic [W-1:0]   I_METER;
   logic           valid_out, last_out, stale_out, busy, overrun, done_sig;

   int checks = 0;
   int failures = 0;

   control_interface_output #(.N_OUT(N), .DATA_W(W), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .sta(sta), .I_s(I_s),
      .exchange_data_sig(exchange_data_sig),
      .I_METER(I_METER), .valid_out(valid_out), .last_out(last_out),
      .stale_out(stale_out), .busy(busy), .overrun(overrun), .done_sig(done_sig)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N*W-1:0] ramp(input logic [W-1:0] base, input logic [W-1:0] step);
      logic [N*W-1:0] v;
      v = '0;
      for (int k = 0; k < N; k++) v[k*W +: W] = base + W'(k) * step;
      return v;
   endfunction

   // Drives an exchange at edge t and checks every cycle through the done pulse.
   task automatic run_stream(input string name, input logic [W-1:0] base, input logic [W-1:0] step,
                             input logic exp_stale, input int mid_c, input logic [N*W-1:0] mid_data);
      logic [W+2:0] got, exp;
      logic [W-1:0] xsum, ew;
      xsum = '0;
      exchange_data_sig = 1'b1;
      tick();
      exchange_data_sig = 1'b0;
      sta = 1'b0;
      checks++;
      if (busy !== 1'b1 || valid_out !== 1'b0) begin
         failures++;
         $display("FAIL %s_arm busy=%b valid=%b required busy=1 valid=0", name, busy, valid_out);
      end
      for (int c = 1; c <= NW + 2; c++) begin
         tick();
         sta = 1'b0;
         if (c + 1 == mid_c) begin
            sta = 1'b1;
            I_s = mid_data;
         end
         if (c == 1) begin
            checks++;
            if (valid_out !== 1'b0) begin
               failures++;
               $display("FAIL %s_lat valid=%b required 0", name, valid_out);
            end
         end else if (c - 2 < NW) begin
            if (c - 2 < N) begin
               ew = base + W'(c - 2) * step;
               xsum = xsum ^ ew;
            end else begin
               ew = xsum;
            end
            exp = {1'b1, (c - 2 == NW - 1), exp_stale, ew};
            got = {valid_out, last_out, stale_out, I_METER};
            checks++;
            if (got !== exp) begin
               failures++;
               $display("FAIL %s_word%0d {valid,last,stale,data}=%h required %h", name, c - 2, got, exp);
            end
         end else begin
            got = {valid_out, done_sig, busy, I_METER};
            exp = {1'b0, 1'b1, 1'b0, {W{1'b0}}};
            checks++;
            if (got !== exp) begin
               failures++;
               $display("FAIL %s_done {valid,done,busy,data}=%h required %h", name, got, exp);
            end
         end
      end
      tick();
      checks++;
      if (done_sig !== 1'b0) begin
         failures++;
         $display("FAIL %s_done_pulse done=%b required 0", name, done_sig);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({I_METER, valid_out, last_out, stale_out, busy, overrun, done_sig} !== '0) begin
         failures++;
         $display("FAIL reset_outputs data=%h flags=%b required all 0", I_METER,
                  {valid_out, last_out, stale_out, busy, overrun, done_sig});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_zero_stale();
      run_stream("zero_stale", 32'h0, 32'h0, 1'b1, -1, '0);
   endtask

   task automatic test_capture();
      sta = 1'b1;
      I_s = ramp(32'h3F800000, 32'h1);
      tick();
      sta = 1'b0;
      tick();
      run_stream("capture", 32'h3F800000, 32'h1, 1'b0, -1, '0);
   endtask

   task automatic test_resend();
      tick();
      run_stream("resend", 32'h3F800000, 32'h1, 1'b1, -1, '0);
   endtask

   task automatic test_same_cycle();
      tick();
      sta = 1'b1;
      I_s = ramp(32'hAAAAAAAA, 32'h0);
      run_stream("same_cycle", 32'hAAAAAAAA, 32'h0, 1'b0, -1, '0);
   endtask

   task automatic test_mid_capture();
      tick();
      sta = 1'b1;
      I_s = ramp(32'hAAAAAAAA, 32'h0);
      run_stream("mid_capture", 32'hAAAAAAAA, 32'h0, 1'b0, 5, ramp(32'h55555555, 32'h0));
      tick();
      run_stream("after_mid", 32'h55555555, 32'h0, 1'b0, -1, '0);
   endtask

   task automatic test_overrun();
      int dones;
      tick();
      checks++;
      if (overrun !== 1'b0) begin
         failures++;
         $display("FAIL overrun_pre overrun=%b required 0", overrun);
      end
      exchange_data_sig = 1'b1;
      tick();                           // edge t
      exchange_data_sig = 1'b0;
      tick();                           // t+1
      tick();                           // t+2
      exchange_data_sig = 1'b1;
      tick();                           // t+3
      exchange_data_sig = 1'b0;
      checks++;
      if ({overrun, valid_out, stale_out, I_METER} !== {3'b111, 32'h55555555}) begin
         failures++;
         $display("FAIL overrun_set {ovr,valid,stale,data}=%h required %h",
                  {overrun, valid_out, stale_out, I_METER}, {3'b111, 32'h55555555});
      end
      tick();                           // t+4
      tick();                           // t+5
      checks++;
      if ({overrun, busy, valid_out} !== 3'b111) begin
         failures++;
         $display("FAIL overrun_sticky {ovr,busy,valid}=%b required 111", {overrun, busy, valid_out});
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({I_METER, valid_out, last_out, stale_out, busy, overrun, done_sig} !== '0) begin
         failures++;
         $display("FAIL abort_reset data=%h flags=%b required all 0", I_METER,
                  {valid_out, last_out, stale_out, busy, overrun, done_sig});
      end
      tick();
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < NW + 4; i++) begin
         tick();
         if (done_sig === 1'b1 || valid_out === 1'b1) dones++;
      end
      checks++;
      if (dones !== 0) begin
         failures++;
         $display("FAIL abort_no_done done_or_valid_cycles=%0d required 0", dones);
      end
      run_stream("post_abort", 32'h0, 32'h0, 1'b1, -1, '0);
   endtask

`ifdef OUTPUT_CHECKSUM_EN
   task automatic test_checksum();
      tick();
      sta = 1'b1;
      I_s = ramp(32'h1, 32'h1);
      run_stream("checksum", 32'h1, 32'h1, 1'b0, -1, '0);
   endtask
`endif

   initial begin
      test_reset();
      test_zero_stale();
      test_capture();
      test_resend();
      test_same_cycle();
      test_mid_capture();
      test_overrun();
`ifdef OUTPUT_CHECKSUM_EN
      test_checksum();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/control_interface_output.md
CONTROL_INTERFACE_OUTPUT -- requirements
Module: control_interface_output

Interface
REQ-001 Parameter N_OUT, default 13, number of output words per exchange.
REQ-002 Parameter DATA_W, default 32, single-precision word width.
REQ-003 Parameter ADDR_W, default 4, word-index counter width; SHALL satisfy 2^ADDR_W >= N_OUT+1.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 sta  input  1  capture pulse; snapshots I_s into the back bank.
REQ-007 I_s  input  N_OUT*DATA_W  flattened solver results; word k at bits [k*DATA_W +: DATA_W].
REQ-008 exchange_data_sig  input  1  stream-start request from the exchange link.
REQ-009 I_METER  output  DATA_W  serial output word, registered.
REQ-010 valid_out  output  1  I_METER holds a valid word.
REQ-011 last_out  output  1  final word of the stream.
REQ-012 stale_out  output  1  current stream carries data already sent, with no capture since.
REQ-013 busy  output  1  high in ARM and SEND.
REQ-014 overrun  output  1  sticky; a request arrived while busy.
REQ-015 done_sig  output  1  one-cycle pulse after the last word.

Function
REQ-016 The block SHALL hold two banks of N_OUT words: a front bank that is streamed and a back bank that is captured; a select bit sel identifies the front bank.
REQ-017 sta SHALL write all N_OUT words of I_s into the back bank in one edge and set flag fresh, in any state.
REQ-018 The FSM SHALL have states IDLE, ARM and SEND.
REQ-019 IDLE->ARM SHALL occur on exchange_data_sig; all other inputs leave the FSM in IDLE.
REQ-020 ARM->SEND SHALL occur unconditionally after one cycle; at the ARM edge, if fresh=1 then sel SHALL toggle and fresh SHALL clear, otherwise sel SHALL hold and stale SHALL latch 1.
REQ-021 A sta in the same cycle as exchange_data_sig SHALL be captured before the ARM swap, so that data is streamed.
REQ-022 A sta during ARM or SEND SHALL write the bank that is back after any swap at that edge, and SHALL NOT alter the words being streamed.
REQ-023 In SEND, index k SHALL run 0..N_OUT-1, one word per cycle, with no gaps.
REQ-024 Latency: for exchange_data_sig sampled at edge t, valid_out SHALL be high for cycles t+2..t+N_OUT+1, carrying front word k at cycle t+2+k.
REQ-025 last_out SHALL be high with the final word; SEND->IDLE SHALL follow it.
REQ-026 done_sig SHALL pulse in cycle t+N_OUT+2.
REQ-027 stale_out SHALL be constant for the whole stream.
REQ-028 exchange_data_sig while busy SHALL be ignored and SHALL set overrun; only reset clears overrun.
REQ-029 When valid_out=0, I_METER SHALL be 0.
REQ-030 Index wrap: k SHALL reset to 0 on SEND exit and SHALL never address beyond N_OUT-1.

Reset
REQ-031 On rst, both banks SHALL clear to 0, with sel=0, fresh=0 and state=IDLE.
REQ-032 On rst, all outputs SHALL be 0.
REQ-033 A reset mid-stream SHALL abort the stream with no done_sig.
REQ-034 The first post-reset stream without a capture SHALL send zeros with stale_out=1.

Configuration
REQ-035 With macro OUTPUT_CHECKSUM_EN defined, SEND SHALL append one word equal to the XOR of the N_OUT streamed words.
REQ-036 With OUTPUT_CHECKSUM_EN defined, valid_out SHALL span N_OUT+1 cycles, last_out SHALL mark the checksum word, and done_sig SHALL move to t+N_OUT+3.
REQ-037 Without OUTPUT_CHECKSUM_EN, the stream SHALL be exactly N_OUT words and no checksum logic SHALL exist.

Verification
REQ-038 Reset -> sta with word k = 32'h3F800000+k -> exchange at t -> words 3F800000..3F80000C at t+2..t+14, last_out at t+14, done_sig at t+15, stale_out=0.
REQ-039 Second exchange with no sta -> same 13 words resent, stale_out=1.
REQ-040 sta with all words 32'hAAAAAAAA in the same cycle as exchange -> AAAAAAAA streamed, stale_out=0.
REQ-041 sta with all words 32'h55555555 at t+5 of a stream of AAAAAAAA -> stream unchanged; next exchange streams 55555555.
REQ-042 exchange at t+3 of a stream -> ignored, overrun=1 until rst; rst at t+6 -> valid_out=0, no done_sig.
REQ-043 OUTPUT_CHECKSUM_EN with words 1..13 -> 14th word 32'h00000001 with last_out, done_sig at t+16.
